param_safecontrol: RTL and testbench

PARAM_SAFECONTROL -- requirements
Module: param_safecontrol

---
 rtl/param_safecontrol_pkg.sv | 16 +
 rtl/param_safecontrol_timer.sv | 30 +++
 rtl/param_safecontrol.sv | 209 ++++++++++++++++++++
 tb/tb_param_safecontrol.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/param_safecontrol_pkg.sv
// Shared types and default key codes for the keypad safe controller.
package safe_pkg;

  typedef enum logic [2:0] {
    ST_LOCKED  = 3'd0,
    ST_CHECK   = 3'd1,
    ST_OPEN    = 3'd2,
    ST_PROG    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  localparam logic [3:0] KEY_ENTER_DEF = 4'hE;
  localparam logic [3:0] KEY_CLEAR_DEF = 4'hC;
  localparam logic [3:0] KEY_PROG_DEF  = 4'hA;

endpackage

// File: rtl/param_safecontrol_timer.sv
// Restartable cycle counter: counts enabled cycles since the last load and
// pulses done_o on the CYCLES-th one. Dropping en_i clears the count.
module safe_timer #(
  parameter int unsigned CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int unsigned W = $clog2(CYCLES + 1);

  logic [W-1:0] cnt_q;

  assign done_o = en_i && !load_i && (cnt_q == W'(CYCLES - 1));

  // Count enabled cycles; restart on load, disable or expiry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i || !en_i || done_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/param_safecontrol.sv
// Keypad safe controller: code entry, check, open/relock, reprogramming and
// lockout after repeated wrong codes. All outputs are registered.
module param_safecontrol
  import safe_pkg::*;
#(
  parameter int unsigned                    CODE_LEN       = 4,
  parameter int unsigned                    DIGIT_W        = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0]    DEFAULT_CODE   = 16'h1234,
  parameter int unsigned                    MAX_FAILS      = 3,
  parameter int unsigned                    LOCKOUT_CYCLES = 4096,
  parameter int unsigned                    OPEN_CYCLES    = 2048,
  parameter int unsigned                    ENTRY_TIMEOUT  = 1024,
  parameter logic [DIGIT_W-1:0]             KEY_ENTER      = DIGIT_W'(KEY_ENTER_DEF),
  parameter logic [DIGIT_W-1:0]             KEY_CLEAR      = DIGIT_W'(KEY_CLEAR_DEF),
  parameter logic [DIGIT_W-1:0]             KEY_PROG       = DIGIT_W'(KEY_PROG_DEF)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             key_valid,
  input  logic [DIGIT_W-1:0]               key_code,
  output logic                             lock,
  output logic                             green,
  output logic                             blue,
  output logic                             alarm,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fails
);

  localparam int unsigned BW = CODE_LEN * DIGIT_W;
  localparam int unsigned CW = $clog2(CODE_LEN + 1);
  localparam int unsigned FW = $clog2(MAX_FAILS + 1);

  state_e          state_q, state_d;
  logic [BW-1:0]   buf_q,   buf_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            ovf_q,   ovf_d;
  logic [BW-1:0]   code_q,  code_d;
  logic [FW-1:0]   fails_q, fails_d;
  logic            lock_q, green_q, blue_q, alarm_q;

  logic key_dig, key_ent, key_clr, key_prg, key_known;
  logic entry_done, open_done, lockout_done;
  logic match;

  assign key_dig   = key_valid && (key_code < DIGIT_W'(10));
  assign key_ent   = key_valid && (key_code == KEY_ENTER);
  assign key_clr   = key_valid && (key_code == KEY_CLEAR);
  assign key_prg   = key_valid && (key_code == KEY_PROG);
  assign key_known = key_dig || key_ent || key_clr || key_prg;

  assign match = (cnt_q == CW'(CODE_LEN)) && !ovf_q && (buf_q == code_q);

  safe_timer #(.CYCLES(ENTRY_TIMEOUT)) u_entry_tmr (
    .clk    (clk),
    .rst    (rst),
    .load_i (key_known),
    .en_i   (((state_q == ST_LOCKED) || (state_q == ST_PROG)) && (cnt_q != '0)),
    .done_o (entry_done)
  );

  safe_timer #(.CYCLES(OPEN_CYCLES)) u_open_tmr (
    .clk    (clk),
    .rst    (rst),
    .load_i (key_known),
    .en_i   (state_q == ST_OPEN),
    .done_o (open_done)
  );

  safe_timer #(.CYCLES(LOCKOUT_CYCLES)) u_lockout_tmr (
    .clk    (clk),
    .rst    (rst),
    .load_i (1'b0),
    .en_i   (state_q == ST_LOCKOUT),
    .done_o (lockout_done)
  );

  // Next-state, entry buffer, stored code and failure counter.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    code_d  = code_q;
    fails_d = fails_q;

    case (state_q)
      ST_LOCKED: begin
        if (key_ent) begin
          state_d = ST_CHECK;
        end else if (key_clr || entry_done) begin
          buf_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (key_dig) begin
          if (cnt_q < CW'(CODE_LEN)) begin
            buf_d = {buf_q[BW-DIGIT_W-1:0], key_code};
            cnt_d = cnt_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end

      ST_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        ovf_d = 1'b0;
        if (match) begin
          state_d = ST_OPEN;
          fails_d = '0;
        end else begin
          fails_d = fails_q + FW'(1);
          state_d = (fails_d == FW'(MAX_FAILS)) ? ST_LOCKOUT : ST_LOCKED;
        end
      end

      ST_OPEN: begin
        if (key_ent) begin
          state_d = ST_LOCKED;
        end else if (key_prg) begin
          state_d = ST_PROG;
          buf_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (open_done) begin
          state_d = ST_LOCKED;
        end
      end

      ST_PROG: begin
        if (key_ent) begin
          if ((cnt_q == CW'(CODE_LEN)) && !ovf_q) begin
            code_d = buf_q;
          end
          state_d = ST_OPEN;
          buf_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end else if (key_clr || entry_done) begin
          // Clear with an empty buffer, or a timeout, abandons programming.
          if ((cnt_q == '0) || entry_done) begin
            state_d = ST_OPEN;
          end
          buf_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
        end else if (key_dig) begin
          if (cnt_q < CW'(CODE_LEN)) begin
            buf_d = {buf_q[BW-DIGIT_W-1:0], key_code};
            cnt_d = cnt_q + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
      end

      ST_LOCKOUT: begin
        if (lockout_done) begin
          state_d = ST_LOCKED;
          fails_d = '0;
          buf_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end

      default: begin
        state_d = ST_LOCKED;
        buf_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers; outputs decoded from next state so they
  // change on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_LOCKED;
      buf_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      code_q  <= DEFAULT_CODE;
      fails_q <= '0;
      lock_q  <= 1'b1;
      green_q <= 1'b0;
      blue_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      code_q  <= code_d;
      fails_q <= fails_d;
      lock_q  <= !((state_d == ST_OPEN) || (state_d == ST_PROG));
      green_q <= (state_d == ST_OPEN) || (state_d == ST_PROG);
      blue_q  <= ((state_d == ST_LOCKED) || (state_d == ST_PROG)) && (cnt_d != '0);
      alarm_q <= (state_d == ST_LOCKOUT);
    end
  end

  assign lock  = lock_q;
  assign green = green_q;
  assign blue  = blue_q;
  assign alarm = alarm_q;
  assign fails = fails_q;

endmodule

// File: tb/tb_param_safecontrol.sv
// Directed bench for param_safecontrol at default parameters.
module tb_param_safecontrol;

  typedef struct {
    logic       valid;
    logic [3:0] code;
    logic       lock;
    logic       green;
    logic       blue;
    logic       alarm;
    logic [1:0] fails;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       lock, green, blue, alarm;
  logic [1:0] fails;

  int tests = 0;
  int errors = 0;
  vec_t vecs[$];

  param_safecontrol dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .lock      (lock),
    .green     (green),
    .blue      (blue),
    .alarm     (alarm),
    .fails     (fails)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_outs(input string name, input logic l, input logic g,
                          input logic b, input logic a, input logic [1:0] f);
    chk({name, ".lock"},  int'(lock),  int'(l));
    chk({name, ".green"}, int'(green), int'(g));
    chk({name, ".blue"},  int'(blue),  int'(b));
    chk({name, ".alarm"}, int'(alarm), int'(a));
    chk({name, ".fails"}, int'(fails), int'(f));
  endtask

  task automatic add(input logic v, input logic [3:0] k, input logic l,
                     input logic g, input logic b, input logic a, input logic [1:0] f);
    vec_t r;
    r.valid = v; r.code = k; r.lock = l; r.green = g;
    r.blue = b; r.alarm = a; r.fails = f;
    vecs.push_back(r);
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic enter4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
    press(a); press(b); press(c); press(d); press(4'hE);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    key_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_outs(name, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    logic [3:0] ks[5];

    // Per-cycle vectors: inputs applied for one clock, outputs after that edge.
    add(1, 4'h1, 1, 0, 1, 0, 0);
    add(1, 4'h2, 1, 0, 1, 0, 0);
    add(0, 4'h0, 1, 0, 1, 0, 0);
    add(1, 4'h3, 1, 0, 1, 0, 0);
    add(1, 4'h4, 1, 0, 1, 0, 0);
    add(1, 4'hE, 1, 0, 0, 0, 0);   // CHECK
    add(0, 4'h0, 0, 1, 0, 0, 0);   // OPEN two edges after ENTER
    add(1, 4'hF, 0, 1, 0, 0, 0);   // unknown key ignored
    add(1, 4'hE, 1, 0, 0, 0, 0);   // relock
    add(1, 4'h1, 1, 0, 1, 0, 0);
    add(1, 4'h2, 1, 0, 1, 0, 0);
    add(1, 4'h3, 1, 0, 1, 0, 0);
    add(1, 4'h5, 1, 0, 1, 0, 0);
    add(1, 4'hE, 1, 0, 0, 0, 0);
    add(1, 4'h7, 1, 0, 0, 0, 1);   // key during CHECK ignored, wrong code
    add(0, 4'h0, 1, 0, 0, 0, 1);
    add(1, 4'h1, 1, 0, 1, 0, 1);
    add(1, 4'hC, 1, 0, 0, 0, 1);   // clear, no failure
    add(1, 4'h1, 1, 0, 1, 0, 1);
    add(1, 4'h2, 1, 0, 1, 0, 1);
    add(1, 4'h3, 1, 0, 1, 0, 1);
    add(1, 4'h4, 1, 0, 1, 0, 1);
    add(1, 4'h5, 1, 0, 1, 0, 1);   // overflow digit
    add(1, 4'hE, 1, 0, 0, 0, 1);
    add(0, 4'h0, 1, 0, 0, 0, 2);   // overflow counts as failure
    add(1, 4'hD, 1, 0, 0, 0, 2);
    add(1, 4'h1, 1, 0, 1, 0, 2);
    add(1, 4'h2, 1, 0, 1, 0, 2);
    add(1, 4'h3, 1, 0, 1, 0, 2);
    add(1, 4'h4, 1, 0, 1, 0, 2);
    add(1, 4'hE, 1, 0, 0, 0, 2);
    add(0, 4'h0, 0, 1, 0, 0, 0);   // open, fails cleared
    add(1, 4'hA, 0, 1, 0, 0, 0);   // PROG
    add(1, 4'h9, 0, 1, 1, 0, 0);
    add(1, 4'h8, 0, 1, 1, 0, 0);
    add(1, 4'h7, 0, 1, 1, 0, 0);
    add(1, 4'h6, 0, 1, 1, 0, 0);
    add(1, 4'hE, 0, 1, 0, 0, 0);   // new code 9876, back to OPEN
    add(1, 4'hE, 1, 0, 0, 0, 0);
    add(1, 4'h9, 1, 0, 1, 0, 0);
    add(1, 4'h8, 1, 0, 1, 0, 0);
    add(1, 4'h7, 1, 0, 1, 0, 0);
    add(1, 4'h6, 1, 0, 1, 0, 0);
    add(1, 4'hE, 1, 0, 0, 0, 0);
    add(0, 4'h0, 0, 1, 0, 0, 0);
    add(1, 4'hE, 1, 0, 0, 0, 0);

    #13;
    chk_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      key_valid = vecs[i].valid;
      key_code  = vecs[i].code;
      @(negedge clk);
      chk_outs($sformatf("row%0d", i), vecs[i].lock, vecs[i].green,
               vecs[i].blue, vecs[i].alarm, vecs[i].fails);
    end
    key_valid = 1'b0;

    // Old code rejected after reprogramming.
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge clk);
    chk_outs("oldcode", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);

    // Reset restores default code and clears fails.
    do_reset("rst_locked");

    // Overflow from a clean start.
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5); press(4'hE);
    @(negedge clk);
    chk_outs("ovf", 1'b1, 1'b0, 1'b0, 1'b0, 2'd1);
    do_reset("rst_ovf");

    // Three wrong entries -> lockout.
    enter4(4'h1, 4'h2, 4'h3, 4'h5);
    @(negedge clk);
    chk("fail1.fails", int'(fails), 1);
    enter4(4'h1, 4'h2, 4'h3, 4'h5);
    @(negedge clk);
    chk("fail2.fails", int'(fails), 2);
    chk("fail2.alarm", int'(alarm), 0);
    enter4(4'h1, 4'h2, 4'h3, 4'h5);
    chk("fail3.check_alarm", int'(alarm), 0);
    @(negedge clk);
    chk("fail3.alarm", int'(alarm), 1);
    chk("fail3.fails", int'(fails), 3);

    ks[0] = 4'h1; ks[1] = 4'h2; ks[2] = 4'h3; ks[3] = 4'h4; ks[4] = 4'hE;
    n = 0;
    while (alarm && n < 5000) begin
      n++;
      if (n <= 10) begin
        key_valid = ((n % 2) == 1);
        key_code  = ks[(n - 1) / 2];
      end else begin
        key_valid = 1'b0;
      end
      @(negedge clk);
    end
    key_valid = 1'b0;
    chk("lockout.cycles", n, 4096);
    chk_outs("lockout.end", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    chk("afterlock.check_lock", int'(lock), 1);
    @(negedge clk);
    chk_outs("afterlock.open", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
    press(4'hE);
    chk("relock.lock", int'(lock), 1);

    // Entry timeout discards buffered digits.
    press(4'h1); press(4'h2);
    chk("timeout.blue_before", int'(blue), 1);
    n = 0;
    while (blue && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout.cycles", n, 1024);
    chk("timeout.fails", int'(fails), 0);
    chk("timeout.lock", int'(lock), 1);

    // Open-idle auto-relock.
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge clk);
    chk("idle.open", int'(lock), 0);
    n = 0;
    while (!lock && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle.cycles", n, 2048);
    chk("idle.green", int'(green), 0);

    // Reset in the middle of programming.
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge clk);
    press(4'hA); press(4'h9); press(4'h8);
    chk("prog.blue", int'(blue), 1);
    do_reset("rst_prog");
    enter4(4'h1, 4'h2, 4'h3, 4'h4);
    @(negedge clk);
    chk_outs("prog.reopen", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
